// File: rtl/cabac_ctx_ram_ctrl_pkg.sv
// Shared widths and FSM encoding for the CABAC context RAM access controller.
package cabac_ctx_ram_ctrl_pkg;

  localparam int CABAC_CTX_ADDR_W = 6;
  localparam int CABAC_CTX_DATA_W = 16;
  localparam int CABAC_CTX_DEPTH  = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } ctx_state_t;

endpackage

// File: rtl/cabac_ctx_ram_ctrl.sv
// Arbitrates init fill > write-back > read onto one low-active context RAM port.
// Read result 2 cycles after accept; writes/reads stall (rdy=0) during init or on conflict.
module cabac_ctx_ram_ctrl
  import cabac_ctx_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = CABAC_CTX_ADDR_W,
  parameter int DATA_W = CABAC_CTX_DATA_W,
  parameter int DEPTH  = CABAC_CTX_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start_i,
  output logic              init_busy_o,
  output logic              init_done_o,
  output logic [ADDR_W-1:0] init_addr_o,
  input  logic [DATA_W-1:0] init_data_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_rdy_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_rdy_o,
  output logic              rd_vld_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              ram_cen_o,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  // One extra counter bit keeps the last-address compare exact.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  ctx_state_t      state, state_nxt;
  logic [ADDR_W:0] cnt, cnt_nxt;
  logic            done_nxt;
  logic            wr_go, rd_go;
  logic            rd_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      init_done_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      init_done_o <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_start_i) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      ST_INIT: begin
        cnt_nxt = cnt + CNT_ONE;
        if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
    endcase
  end

  assign init_busy_o = (state == ST_INIT);
  assign init_addr_o = cnt[ADDR_W-1:0];

  assign wr_rdy_o = (state == ST_IDLE) & ~init_start_i;
  assign rd_rdy_o = wr_rdy_o & ~wr_req_i;
  assign wr_go    = wr_req_i & wr_rdy_o;
  assign rd_go    = rd_req_i & rd_rdy_o;

  always_comb begin
    ram_cen_o  = 1'b1;
    ram_wen_o  = 1'b1;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (state == ST_INIT) begin
      ram_cen_o  = 1'b0;
      ram_wen_o  = 1'b0;
      ram_addr_o = cnt[ADDR_W-1:0];
      ram_data_o = init_data_i;
    end else if (wr_go) begin
      ram_cen_o  = 1'b0;
      ram_wen_o  = 1'b0;
      ram_addr_o = wr_addr_i;
      ram_data_o = wr_data_i;
    end else if (rd_go) begin
      ram_cen_o  = 1'b0;
      ram_addr_o = rd_addr_i;
    end
  end

  // RAM data is valid the cycle after the access; capture it then and flag it one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend   <= 1'b0;
      rd_vld_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_pend  <= rd_go;
      rd_vld_o <= rd_pend;
      if (rd_pend) begin
        rd_data_o <= ram_data_i;
      end
    end
  end

endmodule
